// File: rtl/vga_timing_pkg.sv
// Shared timing constants, beat type and helpers for the raster timing generator.
package vga_timing_pkg;

  // Default 640x480@60 timing (25.175 MHz nominal pixel clock).
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FRONT  = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BACK   = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FRONT  = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BACK   = 33;

  // Coordinate field width carried by a beat; instances use the low CW bits.
  localparam int VGA_BEAT_CW  = 16;

  // Deepest display delay the beat line supports.
  localparam int VGA_MAX_LOOKAHEAD = 8;

  // Total pixels per line (or lines per frame) from the four timing segments.
  function automatic int vga_total(input int active, input int front,
                                   input int sync, input int back);
    return active + front + sync + back;
  endfunction

  // One decoded raster position as it travels from the fetch view to the pins.
  typedef struct packed {
    logic [VGA_BEAT_CW-1:0] x;
    logic [VGA_BEAT_CW-1:0] y;
    logic                   active;
    logic                   hs_act;
    logic                   vs_act;
    logic                   ls;
    logic                   fs;
  } vga_beat_t;

  // Beat shown while in reset: origin, blanked, syncs inactive, no strobes.
  localparam vga_beat_t VGA_BEAT_IDLE = '{
    x:      {VGA_BEAT_CW{1'b0}},
    y:      {VGA_BEAT_CW{1'b0}},
    active: 1'b0,
    hs_act: 1'b0,
    vs_act: 1'b0,
    ls:     1'b0,
    fs:     1'b0
  };

endpackage

// File: rtl/vga_beat_delay.sv
// Fixed-depth delay line for raster beats; depth 0 is a straight wire.
module vga_beat_delay
  import vga_timing_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clock_25mhz,
  input  logic      reset_n,
  input  logic      pix_ce,
  input  vga_beat_t src_beat,
  output vga_beat_t dly_beat,
  output vga_beat_t tail_next
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_ctl_s;

      assign dly_beat    = src_beat;
      assign tail_next   = src_beat;
      assign unused_ctl_s = ^{clock_25mhz, reset_n, pix_ce};
    end else begin : g_shift
      vga_beat_t stage_r [DEPTH];

      // Shift beats one stage per enabled pixel; reset flushes to the idle beat.
      always_ff @(posedge clock_25mhz or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_r[i] <= VGA_BEAT_IDLE;
          end
        end else if (pix_ce) begin
          stage_r[0] <= src_beat;
          for (int i = 1; i < DEPTH; i++) begin
            stage_r[i] <= stage_r[i-1];
          end
        end
      end

      assign dly_beat = stage_r[DEPTH-1];

      // Value the last stage will capture on the next enabled edge.
      if (DEPTH == 1) begin : g_tail_src
        assign tail_next = src_beat;
      end else begin : g_tail_stage
        assign tail_next = stage_r[DEPTH-2];
      end
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator with an early fetch view and a
// delayed display view driving the DAC blanking and sync pins.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE  = VGA_H_ACTIVE,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_ACTIVE  = VGA_V_ACTIVE,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BACK    = VGA_V_BACK,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CW        = 10,
  parameter int LOOKAHEAD = 2,
  parameter int FRAME_W   = 8
) (
  input  logic               clock_25mhz,
  input  logic               reset_n,
  input  logic               pix_ce,
  output logic [CW-1:0]      fetch_x,
  output logic [CW-1:0]      fetch_y,
  output logic               fetch_active,
  output logic [CW-1:0]      x,
  output logic [CW-1:0]      y,
  output logic               in_active_area,
  output logic               hsync,
  output logic               vsync,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count
);

  localparam int H_TOTAL = vga_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = vga_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);

  localparam bit PARAMS_OK =
      (H_ACTIVE > 0) && (H_FRONT > 0) && (H_SYNC > 0) && (H_BACK > 0) &&
      (V_ACTIVE > 0) && (V_FRONT > 0) && (V_SYNC > 0) && (V_BACK > 0) &&
      (LOOKAHEAD >= 0) && (LOOKAHEAD <= VGA_MAX_LOOKAHEAD) &&
      (CW > 0) && (CW <= VGA_BEAT_CW) && (FRAME_W > 0) &&
      ((longint'(1) << CW) >= longint'(H_TOTAL)) &&
      ((longint'(1) << CW) >= longint'(V_TOTAL));

  generate
    if (!PARAMS_OK) begin : g_param_check
      $error("vga_timing_gen: illegal timing, width or lookahead parameters");
    end
  endgenerate

  // Decode thresholds sized to the counters.
  localparam logic [CW-1:0] H_LAST_C = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST_C = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG_C = CW'(H_ACTIVE + H_FRONT);
  localparam logic [CW-1:0] HS_END_C = CW'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [CW-1:0] VS_BEG_C = CW'(V_ACTIVE + V_FRONT);
  localparam logic [CW-1:0] VS_END_C = CW'(V_ACTIVE + V_FRONT + V_SYNC - 1);

  logic [CW-1:0]      hc_r;
  logic [CW-1:0]      vc_r;
  logic               wrapped_r;
  logic               raster_end_s;
  logic               tail_fs_s;
  logic [FRAME_W-1:0] frame_count_r;
  vga_beat_t          dec_s;
  vga_beat_t          fetch_r;
  vga_beat_t          disp_s;
  vga_beat_t          tail_s;
  logic               unused_bits_s;

  assign raster_end_s = (hc_r == H_LAST_C) && (vc_r == V_LAST_C);

  // Raster position counters: pixel within line, then line within frame.
  always_ff @(posedge clock_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      hc_r <= {CW{1'b0}};
      vc_r <= {CW{1'b0}};
    end else if (pix_ce) begin
      if (hc_r == H_LAST_C) begin
        hc_r <= {CW{1'b0}};
        if (vc_r == V_LAST_C) begin
          vc_r <= {CW{1'b0}};
        end else begin
          vc_r <= vc_r + CW'(1);
        end
      end else begin
        hc_r <= hc_r + CW'(1);
      end
    end
  end

  // Remember that the raster wrapped; only frame starts after that are counted.
  always_ff @(posedge clock_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      wrapped_r <= 1'b0;
    end else if (pix_ce && raster_end_s) begin
      wrapped_r <= 1'b1;
    end
  end

  // Build the beat for the current counter position.
  always_comb begin
    dec_s        = VGA_BEAT_IDLE;
    dec_s.x      = VGA_BEAT_CW'(hc_r);
    dec_s.y      = VGA_BEAT_CW'(vc_r);
    dec_s.active = (hc_r < H_ACT_C) && (vc_r < V_ACT_C);
    dec_s.hs_act = (hc_r >= HS_BEG_C) && (hc_r <= HS_END_C);
    dec_s.vs_act = (vc_r >= VS_BEG_C) && (vc_r <= VS_END_C);
    dec_s.ls     = (hc_r == {CW{1'b0}});
    dec_s.fs     = (hc_r == {CW{1'b0}}) && (vc_r == {CW{1'b0}});
  end

  // Decode register: this is the fetch view.
  always_ff @(posedge clock_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      fetch_r <= VGA_BEAT_IDLE;
    end else if (pix_ce) begin
      fetch_r <= dec_s;
    end
  end

  vga_beat_delay #(
    .DEPTH (LOOKAHEAD)
  ) u_beat_delay (
    .clock_25mhz (clock_25mhz),
    .reset_n     (reset_n),
    .pix_ce      (pix_ce),
    .src_beat    (fetch_r),
    .dly_beat    (disp_s),
    .tail_next   (tail_s)
  );

  // With no delay the display view is the decode register, fed by dec_s.
  assign tail_fs_s = (LOOKAHEAD == 0) ? dec_s.fs : tail_s.fs;

  // Count completed frames in step with the display frame_start strobe.
  always_ff @(posedge clock_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      frame_count_r <= {FRAME_W{1'b0}};
    end else if (pix_ce && wrapped_r && tail_fs_s) begin
      frame_count_r <= frame_count_r + FRAME_W'(1);
    end
  end

  assign fetch_x        = fetch_r.x[CW-1:0];
  assign fetch_y        = fetch_r.y[CW-1:0];
  assign fetch_active   = fetch_r.active;

  assign x              = disp_s.x[CW-1:0];
  assign y              = disp_s.y[CW-1:0];
  assign in_active_area = disp_s.active;
  assign hsync          = disp_s.hs_act ? HSYNC_POL : ~HSYNC_POL;
  assign vsync          = disp_s.vs_act ? VSYNC_POL : ~VSYNC_POL;
  assign line_start     = disp_s.ls;
  assign frame_start    = disp_s.fs;
  assign frame_count    = frame_count_r;

  // Fields not routed to pins (upper coordinate bits, fetch syncs, tail beat).
  assign unused_bits_s  = ^{fetch_r, disp_s, tail_s};

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: three instances (640x480 lookahead 2,
// a tiny positive-polarity raster with lookahead 1, 800x600 with lookahead 0).
module tb_vga_timing_gen;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic        act;
    logic        hs;
    logic        vs;
    logic        ls;
    logic        fs;
  } beat_t;
  typedef beat_t [2:0] trio_t;

  int    HA [3] = '{640, 8, 800};
  int    HF [3] = '{16, 2, 40};
  int    HS [3] = '{96, 3, 128};
  int    HB [3] = '{48, 3, 88};
  int    VA [3] = '{480, 6, 600};
  int    VF [3] = '{10, 1, 1};
  int    VS [3] = '{2, 2, 4};
  int    VB [3] = '{33, 1, 23};
  int    LA [3] = '{2, 1, 0};
  logic  HP [3] = '{1'b0, 1'b1, 1'b1};
  logic  VP [3] = '{1'b0, 1'b1, 1'b1};
  string NM [3] = '{"A", "B", "C"};

  logic clk = 1'b0;
  logic reset_n;
  logic pix_ce;

  logic [9:0]  a_fx, a_fy, a_x, a_y;
  logic        a_fa, a_act, a_hs, a_vs, a_ls, a_fs;
  logic [7:0]  a_fc;
  logic [4:0]  b_fx, b_fy, b_x, b_y;
  logic        b_fa, b_act, b_hs, b_vs, b_ls, b_fs;
  logic [7:0]  b_fc;
  logic [10:0] c_fx, c_fy, c_x, c_y;
  logic        c_fa, c_act, c_hs, c_vs, c_ls, c_fs;
  logic [7:0]  c_fc;

  trio_t hist[$];
  int    m_hc [3];
  int    m_vc [3];
  int    n_fs [3];
  int    cyc;
  int    n_vec;
  int    n_err;

  always #5 clk = ~clk;

  vga_timing_gen #(.LOOKAHEAD(2)) u_a (
    .clock_25mhz(clk), .reset_n(reset_n), .pix_ce(pix_ce),
    .fetch_x(a_fx), .fetch_y(a_fy), .fetch_active(a_fa),
    .x(a_x), .y(a_y), .in_active_area(a_act), .hsync(a_hs), .vsync(a_vs),
    .line_start(a_ls), .frame_start(a_fs), .frame_count(a_fc));

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_ACTIVE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CW(5), .LOOKAHEAD(1), .FRAME_W(8)
  ) u_b (
    .clock_25mhz(clk), .reset_n(reset_n), .pix_ce(pix_ce),
    .fetch_x(b_fx), .fetch_y(b_fy), .fetch_active(b_fa),
    .x(b_x), .y(b_y), .in_active_area(b_act), .hsync(b_hs), .vsync(b_vs),
    .line_start(b_ls), .frame_start(b_fs), .frame_count(b_fc));

  vga_timing_gen #(
    .H_ACTIVE(800), .H_FRONT(40), .H_SYNC(128), .H_BACK(88),
    .V_ACTIVE(600), .V_FRONT(1), .V_SYNC(4), .V_BACK(23),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CW(11), .LOOKAHEAD(0), .FRAME_W(8)
  ) u_c (
    .clock_25mhz(clk), .reset_n(reset_n), .pix_ce(pix_ce),
    .fetch_x(c_fx), .fetch_y(c_fy), .fetch_active(c_fa),
    .x(c_x), .y(c_y), .in_active_area(c_act), .hsync(c_hs), .vsync(c_vs),
    .line_start(c_ls), .frame_start(c_fs), .frame_count(c_fc));

  function automatic int htot(input int i);
    return HA[i] + HF[i] + HS[i] + HB[i];
  endfunction

  function automatic int vtot(input int i);
    return VA[i] + VF[i] + VS[i] + VB[i];
  endfunction

  // Expected beat for raster position (hc, vc) of instance i.
  function automatic beat_t mk(input int i, input int hc, input int vc);
    beat_t b;
    b.x   = 11'(hc);
    b.y   = 11'(vc);
    b.act = (hc < HA[i]) && (vc < VA[i]);
    b.hs  = (hc >= HA[i] + HF[i]) && (hc < HA[i] + HF[i] + HS[i]);
    b.vs  = (vc >= VA[i] + VF[i]) && (vc < VA[i] + VF[i] + VS[i]);
    b.ls  = (hc == 0);
    b.fs  = (hc == 0) && (vc == 0);
    return b;
  endfunction

  function automatic logic [63:0] pack_out(
      input logic [10:0] fx, input logic [10:0] fy, input logic fa,
      input logic [10:0] dx, input logic [10:0] dy, input logic act,
      input logic hs, input logic vs, input logic ls, input logic fs,
      input logic [7:0] fc);
    return {6'd0, fx, fy, fa, dx, dy, act, hs, vs, ls, fs, fc};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    trio_t idle;
    idle = '0;
    for (int i = 0; i < 3; i++) begin
      m_hc[i] = 0;
      m_vc[i] = 0;
      n_fs[i] = 0;
    end
    hist.delete();
    for (int k = 0; k < 9; k++) hist.push_back(idle);
  endtask

  // Compare every output of every instance against the scoreboard.
  task automatic check_all();
    trio_t f, d;
    beat_t fb, db;
    logic [63:0] e, o;
    logic [7:0] efc;
    f = hist[hist.size() - 1];
    for (int i = 0; i < 3; i++) begin
      d   = hist[hist.size() - 1 - LA[i]];
      fb  = f[i];
      db  = d[i];
      efc = (n_fs[i] == 0) ? 8'd0 : 8'(n_fs[i] - 1);
      e = pack_out(fb.x, fb.y, fb.act, db.x, db.y, db.act,
                   db.hs ? HP[i] : ~HP[i], db.vs ? VP[i] : ~VP[i],
                   db.ls, db.fs, efc);
      case (i)
        0:       o = pack_out(11'(a_fx), 11'(a_fy), a_fa, 11'(a_x), 11'(a_y), a_act,
                              a_hs, a_vs, a_ls, a_fs, a_fc);
        1:       o = pack_out(11'(b_fx), 11'(b_fy), b_fa, 11'(b_x), 11'(b_y), b_act,
                              b_hs, b_vs, b_ls, b_fs, b_fc);
        default: o = pack_out(c_fx, c_fy, c_fa, c_x, c_y, c_act,
                              c_hs, c_vs, c_ls, c_fs, c_fc);
      endcase
      chk({NM[i], ".outputs"}, o, e);
    end
  endtask

  // One clock: drive pix_ce, advance the model on enabled edges, compare.
  task automatic tick(input logic ce);
    trio_t t, d;
    pix_ce = ce;
    @(posedge clk);
    #1;
    cyc++;
    if (ce && reset_n) begin
      for (int i = 0; i < 3; i++) begin
        t[i] = mk(i, m_hc[i], m_vc[i]);
        if (m_hc[i] == htot(i) - 1) begin
          m_hc[i] = 0;
          m_vc[i] = (m_vc[i] == vtot(i) - 1) ? 0 : m_vc[i] + 1;
        end else begin
          m_hc[i] = m_hc[i] + 1;
        end
      end
      hist.push_back(t);
      if (hist.size() > 9) hist.delete(0);
      for (int i = 0; i < 3; i++) begin
        d = hist[hist.size() - 1 - LA[i]];
        if (d[i].fs) n_fs[i]++;
      end
    end
    check_all();
  endtask

  int a_last, a_per, a_hs_low, a_hs_first, a_run, run;
  int c_last, c_per, c_hs_hi, c_hs_first;
  int b_vs_ymin, b_vs_ymax, nfs, k;
  logic a_prev, c_prev;

  initial begin
    cyc = 0; n_vec = 0; n_err = 0;
    pix_ce  = 1'b0;
    reset_n = 1'b1;
    model_reset();
    #1 reset_n = 1'b0;
    #1;
    check_all();
    chk("A.reset_hsync", 64'(a_hs), 64'd1);
    chk("B.reset_vsync", 64'(b_vs), 64'd0);
    tick(1'b1);
    tick(1'b1);
    @(negedge clk);
    reset_n = 1'b1;

    // First enabled edges after release.
    tick(1'b1);
    chk("A.fetch_x_e1", 64'(a_fx), 64'd0);
    chk("A.fetch_active_e1", 64'(a_fa), 64'd1);
    chk("A.in_active_e1", 64'(a_act), 64'd0);
    tick(1'b1);
    chk("A.fetch_x_e2", 64'(a_fx), 64'd1);
    chk("A.frame_start_e2", 64'(a_fs), 64'd0);
    tick(1'b1);
    chk("A.fetch_x_e3", 64'(a_fx), 64'd2);
    chk("A.frame_start_e3", 64'(a_fs), 64'd1);
    chk("A.in_active_e3", 64'(a_act), 64'd1);
    chk("A.frame_count_first", 64'(a_fc), 64'd0);

    // Line timing with pix_ce held high.
    a_last = -1; a_per = 0; a_hs_low = 0; a_hs_first = -1;
    c_last = -1; c_per = 0; c_hs_hi = 0; c_hs_first = -1;
    b_vs_ymin = 99; b_vs_ymax = -1; a_prev = a_ls; c_prev = c_ls;
    for (int j = 0; j < 2200; j++) begin
      tick(1'b1);
      if (a_ls && !a_prev) begin
        if (a_last >= 0) a_per = cyc - a_last;
        a_last = cyc;
      end
      if (c_ls && !c_prev) begin
        if (c_last >= 0) c_per = cyc - c_last;
        c_last = cyc;
      end
      a_prev = a_ls; c_prev = c_ls;
      if (a_y == 10'd0 && !a_hs) begin
        a_hs_low++;
        if (a_hs_first < 0) a_hs_first = int'(a_x);
      end
      if (c_y == 11'd0 && c_hs) begin
        c_hs_hi++;
        if (c_hs_first < 0) c_hs_first = int'(c_x);
      end
      if (b_vs) begin
        if (int'(b_y) < b_vs_ymin) b_vs_ymin = int'(b_y);
        if (int'(b_y) > b_vs_ymax) b_vs_ymax = int'(b_y);
      end
    end
    chk("A.line_period", 64'(a_per), 64'd800);
    chk("A.hsync_low_count", 64'(a_hs_low), 64'd96);
    chk("A.hsync_first_x", 64'(a_hs_first), 64'd656);
    chk("C.line_period", 64'(c_per), 64'd1056);
    chk("C.hsync_high_count", 64'(c_hs_hi), 64'd128);
    chk("C.hsync_first_x", 64'(c_hs_first), 64'd840);
    chk("B.vsync_first_y", 64'(b_vs_ymin), 64'd7);
    chk("B.vsync_last_y", 64'(b_vs_ymax), 64'd8);

    // Pixel-repeat: pix_ce alternating 1,0.
    a_last = -1; a_per = 0; run = 0; a_run = 0; a_prev = a_ls;
    for (int j = 0; j < 3400; j++) begin
      tick((j % 2) == 0 ? 1'b1 : 1'b0);
      if (a_ls) run++;
      else if (run > 0) begin
        a_run = run;
        run = 0;
      end
      if (a_ls && !a_prev) begin
        if (a_last >= 0) a_per = cyc - a_last;
        a_last = cyc;
      end
      a_prev = a_ls;
    end
    chk("A.ce_line_period", 64'(a_per), 64'd1600);
    chk("A.ce_line_start_width", 64'(a_run), 64'd2);

    // Asynchronous reset in the middle of a line.
    k = 0;
    while (a_fx != 10'd300 && k < 2000) begin
      tick(1'b1);
      k++;
    end
    chk("A.reach_fetch_x_300", 64'(a_fx), 64'd300);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("A.midrst_in_active", 64'(a_act), 64'd0);
    chk("A.midrst_hsync", 64'(a_hs), 64'd1);
    chk("A.midrst_vsync", 64'(a_vs), 64'd1);
    chk("B.midrst_frame_count", 64'(b_fc), 64'd0);
    chk("B.midrst_hsync", 64'(b_hs), 64'd0);
    tick(1'b1);
    tick(1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    nfs = 0;
    for (int j = 0; j < 3; j++) begin
      tick(1'b1);
      chk("A.restart_fetch_x", 64'(a_fx), 64'(j));
      if (b_fs) nfs++;
    end

    // Frame counter: first frame_start ignored, then 3, then 256 more.
    k = 0;
    while (nfs < 4 && k < 800) begin
      tick(1'b1);
      if (b_fs) nfs++;
      k++;
    end
    chk("B.frame_starts_seen_4", 64'(nfs), 64'd4);
    chk("B.frame_count_3", 64'(b_fc), 64'd3);
    k = 0;
    while (nfs < 260 && k < 256 * 160 + 400) begin
      tick(1'b1);
      if (b_fs) nfs++;
      k++;
    end
    chk("B.frame_starts_seen_260", 64'(nfs), 64'd260);
    chk("B.frame_count_wrap", 64'(b_fc), 64'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
